// File: rtl/sha3_block_padder.sv
// Packs 64-bit message beats into SHA3-256 rate blocks, applies 0x06..0x80
// padding, and issues one block at a time to the permutation core.
module sha3_block_padder #(
    parameter int RATE_W  = 1088,
    parameter bit BIT_REV = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       s_data,
    input  logic [3:0]        s_nbytes,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [RATE_W-1:0] blk_data,
    output logic              blk_valid,
    output logic              blk_more,
    input  logic              hash_next_i,
    input  logic              out_valid_i,
    output logic              msg_done
);
    localparam int NWORDS = RATE_W / 64;
    localparam int NBYTES = RATE_W / 8;
    localparam int WCW    = $clog2(NWORDS);
    localparam int LW     = $clog2(NBYTES + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;

    logic [RATE_W-1:0] asm_q, asm_beat, asm_out, pad_blk;
    logic [WCW-1:0]    wcnt;
    logic              asm_full, asm_final, pad_pend, rdy_en;
    logic [63:0]       beat_word;
    logic [LW-1:0]     end_byte;
    logic              beat, issue_go, fin_go;

    // rdy_en keeps s_ready low for the cycle reset is asserted
    assign s_ready  = rdy_en & ~asm_full & ~pad_pend;
    assign beat     = s_valid & s_ready;
    assign end_byte = LW'({wcnt, 3'b000}) + LW'(s_nbytes);

    always_comb begin
        pad_blk               = '0;
        pad_blk[RATE_W-1 -: 8] = 8'h06;
        pad_blk[7:0]          = 8'h80;
    end

    // Next assembly contents for an accepted beat, including in-block padding on s_last
    always_comb begin
        beat_word = '0;
        for (int k = 0; k < 8; k++)
            if (4'(k) < s_nbytes) beat_word[63-8*k -: 8] = s_data[63-8*k -: 8];
        asm_beat = asm_q;
        for (int w = 0; w < NWORDS; w++) begin
            if (WCW'(w) == wcnt)
                asm_beat[RATE_W-1-64*w -: 64] = beat_word;
            else if (s_last && (WCW'(w) > wcnt))
                asm_beat[RATE_W-1-64*w -: 64] = '0;
        end
        if (s_last && (end_byte != LW'(NBYTES))) begin
            for (int b = 0; b < NBYTES; b++)
                if (LW'(b) == end_byte)
                    asm_beat[RATE_W-1-8*b -: 8] = asm_beat[RATE_W-1-8*b -: 8] ^ 8'h06;
            asm_beat[7:0] = asm_beat[7:0] ^ 8'h80;
        end
    end

    always_comb begin
        asm_out = asm_q;
        if (BIT_REV)
            for (int b = 0; b < NBYTES; b++)
                for (int i = 0; i < 8; i++)
                    asm_out[8*b+i] = asm_q[8*b+7-i];
    end

    // Issue clears asm_full; beats and pad loads only happen while it is clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            wcnt      <= '0;
            asm_full  <= 1'b0;
            asm_final <= 1'b0;
            pad_pend  <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (issue_go) begin
                asm_full  <= 1'b0;
                asm_final <= 1'b0;
            end else if (pad_pend && !asm_full) begin
                asm_q     <= pad_blk;
                asm_full  <= 1'b1;
                asm_final <= 1'b1;
                pad_pend  <= 1'b0;
            end else if (beat) begin
                asm_q <= asm_beat;
                if (s_last) begin
                    wcnt      <= '0;
                    asm_full  <= 1'b1;
                    asm_final <= (end_byte != LW'(NBYTES));
                    pad_pend  <= (end_byte == LW'(NBYTES));
                end else if (wcnt == WCW'(NWORDS - 1)) begin
                    wcnt     <= '0;
                    asm_full <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (asm_full) state_d = BUSY;
        end else begin
            if (hash_next_i || out_valid_i) state_d = IDLE;
        end
    end

    // Completion pulses seen while IDLE are ignored
    always_comb begin
        issue_go = (state_q == IDLE) && asm_full;
        fin_go   = (state_q == BUSY) && out_valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data  <= '0;
            blk_valid <= 1'b0;
            blk_more  <= 1'b0;
            msg_done  <= 1'b0;
        end else begin
            blk_valid <= issue_go;
            msg_done  <= fin_go;
            if (issue_go) begin
                blk_data <= asm_out;
                blk_more <= ~asm_final;
            end else if (fin_go) begin
                blk_more <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha3_block_padder.sv
// Scoreboard bench: random messages are padded by a byte-queue reference
// model; a monitor compares each issued block against it.
module tb_sha3_block_padder;
    localparam int RW = 1088;
    localparam int NB = RW / 8;

    typedef byte unsigned bq_t[$];
    typedef struct {
        logic [RW-1:0] raw;
        bit            more;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [63:0]   s_data = '0;
    logic [3:0]    s_nbytes = '0;
    logic          s_last = 1'b0, s_valid = 1'b0;
    logic          hash_next_i = 1'b0, out_valid_i = 1'b0;
    logic          s_ready, blk_valid, blk_more, msg_done;
    logic [RW-1:0] blk_data;
    logic          s_ready_n, blk_valid_n, blk_more_n, msg_done_n;
    logic [RW-1:0] blk_data_n;

    exp_t expq[$];
    int   checks = 0, failures = 0;
    int   dones_exp = 0, dones_seen = 0, core_dly = 0, epoch = 0;
    bit   core_busy = 1'b0;

    always #5 clk = ~clk;

    sha3_block_padder #(.RATE_W(RW), .BIT_REV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_nbytes(s_nbytes),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_more(blk_more),
        .hash_next_i(hash_next_i), .out_valid_i(out_valid_i), .msg_done(msg_done));

    sha3_block_padder #(.RATE_W(RW), .BIT_REV(1'b0)) dut_norev (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_nbytes(s_nbytes),
        .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready_n),
        .blk_data(blk_data_n), .blk_valid(blk_valid_n), .blk_more(blk_more_n),
        .hash_next_i(hash_next_i), .out_valid_i(out_valid_i), .msg_done(msg_done_n));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            failures++;
            idx = 0;
            for (int i = NB - 1; i >= 0; i--)
                if (act[RW-1-8*i -: 8] !== exp[RW-1-8*i -: 8]) idx = i;
            $display("FAIL %s byte=%0d actual=%02h required=%02h", name, idx,
                     act[RW-1-8*idx -: 8], exp[RW-1-8*idx -: 8]);
        end
    endtask

    function automatic logic [RW-1:0] rev_bytes(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 8; i++) r[8*b+i] = v[8*b+7-i];
        return r;
    endfunction

    function automatic bq_t rand_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // SHA3 pad10*1 with domain byte 0x06, split into rate blocks
    function automatic void push_exp(input bq_t m, input int maxb);
        bq_t  p;
        exp_t e;
        int   nblk;
        p = m;
        p.push_back(8'h06);
        while (p.size() % NB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / NB;
        for (int b = 0; b < nblk && b < maxb; b++) begin
            e.raw = '0;
            for (int i = 0; i < NB; i++) e.raw[RW-1-8*i -: 8] = p[b*NB+i];
            e.more = (b < nblk - 1);
            expq.push_back(e);
        end
    endfunction

    task automatic put_beat(input logic [63:0] d, input logic [3:0] nb, input logic last,
                            input int gap_max);
        int n;
        n = 0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        s_data = d; s_nbytes = nb; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL s_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        s_data = {$urandom, $urandom}; s_nbytes = 4'($urandom_range(0, 8));
    endtask

    task automatic send_msg(input bq_t m, input int gap_max, input int stop_after);
        int len, nbeats, nb;
        logic [63:0] d;
        len    = m.size();
        nbeats = (len == 0) ? 1 : (len + 7) / 8;
        for (int j = 0; j < nbeats; j++) begin
            if (stop_after >= 0 && j >= stop_after) break;
            d  = {$urandom, $urandom};
            nb = (len - 8*j > 8) ? 8 : len - 8*j;
            for (int k = 0; k < nb; k++) d[63-8*k -: 8] = m[8*j+k];
            put_beat(d, 4'(nb), (j == nbeats - 1), gap_max);
        end
    endtask

    task automatic wait_idle();
        int n, quiet;
        n = 0; quiet = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk); n++;
            if (expq.size() == 0 && !core_busy) quiet++; else quiet = 0;
        end
        if (n >= 5000) begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=%0d required=0", expq.size());
        end
    endtask

    // Core stand-in: answers each issued block after a delay with hash_next or out_valid
    initial begin : core
        logic m;
        int   d, ep;
        forever begin
            @(negedge clk);
            if (blk_valid === 1'b1) begin
                m = blk_more; ep = epoch; core_busy = 1'b1;
                d = (core_dly > 0) ? core_dly : $urandom_range(1, 12);
                repeat (d) @(negedge clk);
                if (m) hash_next_i = 1'b1;
                else begin
                    out_valid_i = 1'b1;
                    hash_next_i = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                hash_next_i = 1'b0; out_valid_i = 1'b0;
                if (!m && ep == epoch) begin
                    dones_exp++;
                    chk("msg_done_pulse", msg_done, 1);
                    chk("more_cleared_on_done", blk_more, 0);
                end
                core_busy = 1'b0;
            end
        end
    end

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (msg_done === 1'b1) dones_seen++;
            if (blk_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL blk_unexpected actual=1 required=0");
                end else begin
                    e = expq.pop_front();
                    chk_blk("blk_data_rev", blk_data, rev_bytes(e.raw));
                    chk_blk("blk_data_norev", blk_data_n, e.raw);
                    chk("blk_more", blk_more, 64'(e.more));
                    chk("blk_valid_norev", blk_valid_n, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bq_t m;
        int  seen, n, len;
        bit  bad;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_more", blk_more, 0);
        chk("rst_msg_done", msg_done, 0);
        chk_blk("rst_blk_data", blk_data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1);

        // empty message, then 135 bytes (0x86 in the last byte)
        m = rand_msg(0);   push_exp(m, 99); send_msg(m, 2, -1);
        m = rand_msg(135); push_exp(m, 99); send_msg(m, 2, -1);
        wait_idle();

        // 136 bytes: data block then pad-only block, input stalled throughout
        m = rand_msg(136); push_exp(m, 99); send_msg(m, 1, -1);
        seen = 0; bad = 1'b0; n = 0;
        while (seen < 2 && n < 1000) begin
            if (blk_valid) begin
                seen++;
                if (seen == 1 && s_ready) bad = 1'b1;
            end else if (s_ready) bad = 1'b1;
            n++;
            if (seen < 2) @(negedge clk);
        end
        chk("s_ready_low_until_pad", 64'(bad), 0);
        chk("pad_block_issued", seen, 2);
        wait_idle();

        // back-to-back beats, assembly outruns the core
        m = rand_msg(300); push_exp(m, 99); send_msg(m, 0, -1);

        // overlapping random messages of random lengths
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 4))
                0:       len = 135 + $urandom_range(0, 1) + 136 * $urandom_range(0, 1);
                default: len = $urandom_range(0, 400);
            endcase
            m = rand_msg(len); push_exp(m, 99); send_msg(m, $urandom_range(0, 3), -1);
        end
        wait_idle();

        // reset with block 1 in flight and block 2 at word 9
        core_dly = 60;
        m = rand_msg(300); push_exp(m, 1); send_msg(m, 0, 26);
        epoch++;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_blk_valid", blk_valid, 0);
        chk("midrst_blk_more", blk_more, 0);
        chk("midrst_msg_done", msg_done, 0);
        chk_blk("midrst_blk_data", blk_data, '0);
        rst_n = 1'b1;
        core_dly = 0;
        wait_idle();

        m = '{8'h61, 8'h62, 8'h63}; push_exp(m, 99); send_msg(m, 0, -1);
        wait_idle();

        chk("scoreboard_empty", expq.size(), 0);
        chk("msg_done_count", dones_seen, dones_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
